// File: rtl/pa_fp_pkg.sv
// Shared floating-point adder definitions: default field widths, packed
// operand field offsets and the operand record type.
package pa_fp_pkg;

    localparam int unsigned DEF_EXP_W = 8;
    localparam int unsigned DEF_MAN_W = 28;
    localparam int unsigned DEF_PKT_W = 1 + DEF_EXP_W + DEF_MAN_W;

    // Field offsets inside a packed {sign, exp, mant} operand
    localparam int unsigned SIGN_BIT = DEF_PKT_W - 1;
    localparam int unsigned EXP_MSB  = DEF_PKT_W - 2;
    localparam int unsigned EXP_LSB  = DEF_MAN_W;
    localparam int unsigned MAN_MSB  = DEF_MAN_W - 1;
    localparam int unsigned MAN_LSB  = 0;

    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] mant;
    } fp_operand_t;

endpackage

// File: rtl/pa_mag_swap.sv
// Magnitude swap and sign resolution for an aligned operand pair.
// Inputs : ge/eq (mant_a >= / == mant_b), sa, sb, mant_a, mant_b
// Outputs: ma_c (larger), mb_c (smaller), eff_sub_c, sr_c, zero_res_c
// Purely combinational so the single-cycle adder can reuse it.
module pa_mag_swap
    import pa_fp_pkg::*;
#(
    parameter int unsigned MAN_W = DEF_MAN_W
) (
    input  logic             ge,
    input  logic             eq,
    input  logic             sa,
    input  logic             sb,
    input  logic [MAN_W-1:0] mant_a,
    input  logic [MAN_W-1:0] mant_b,
    output logic [MAN_W-1:0] ma_c,
    output logic [MAN_W-1:0] mb_c,
    output logic             eff_sub_c,
    output logic             sr_c,
    output logic             zero_res_c
);

    always_comb begin
        ma_c       = ge ? mant_a : mant_b;
        mb_c       = ge ? mant_b : mant_a;
        eff_sub_c  = sa ^ sb;
        zero_res_c = eff_sub_c & eq;
        sr_c       = sa;
        // Exact cancellation yields +0 under round-to-nearest
        if (eff_sub_c) begin
            if (eq) begin
                sr_c = 1'b0;
            end else begin
                sr_c = ge ? sa : sb;
            end
        end
    end

endmodule

// File: rtl/pa_mag_order_pipe.sv
// Two-stage magnitude-ordering pipeline for the FP adder.
// S1 captures split operand fields plus compare flags; S2 holds the
// ordered mantissas, common exponent, signs and result-sign/status flags.
// Ports: clk, rst_n; in_valid/in_ready with num_a/num_b {sign,exp,mant};
//        out_valid/out_ready with sa, sb, comp, eo, ma, mb, eff_sub, sr,
//        zero_res, align_err.
module pa_mag_order_pipe
    import pa_fp_pkg::*;
#(
    parameter  int unsigned EXP_W = DEF_EXP_W,
    parameter  int unsigned MAN_W = DEF_MAN_W,
    localparam int unsigned PKT_W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] num_a,
    input  logic [PKT_W-1:0] num_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sa,
    output logic             sb,
    output logic             comp,
    output logic [EXP_W-1:0] eo,
    output logic [MAN_W-1:0] ma,
    output logic [MAN_W-1:0] mb,
    output logic             eff_sub,
    output logic             sr,
    output logic             zero_res,
    output logic             align_err
);

    // Input field split
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;

    assign a_sign = num_a[PKT_W-1];
    assign b_sign = num_b[PKT_W-1];
    assign a_exp  = num_a[PKT_W-2 -: EXP_W];
    assign b_exp  = num_b[PKT_W-2 -: EXP_W];
    assign a_man  = num_a[MAN_W-1:0];
    assign b_man  = num_b[MAN_W-1:0];

    // S1 state
    logic             s1_valid;
    logic             s1_sa, s1_sb;
    logic [EXP_W-1:0] s1_ea;
    logic [MAN_W-1:0] s1_ma, s1_mb;
    logic             s1_ge, s1_eq, s1_xerr;

    logic s2_adv, s1_adv;

    // Advance chain depends only on registered valids and out_ready
    assign s2_adv    = !out_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;

    // S1: capture operands and compare flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_ea    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_ge    <= 1'b0;
            s1_eq    <= 1'b0;
            s1_xerr  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sa   <= a_sign;
                s1_sb   <= b_sign;
                s1_ea   <= a_exp;
                s1_ma   <= a_man;
                s1_mb   <= b_man;
                s1_ge   <= (a_man >= b_man);
                s1_eq   <= (a_man == b_man);
                s1_xerr <= (a_exp != b_exp);
            end
        end
    end

    // S2 combinational ordering
    logic [MAN_W-1:0] sw_ma, sw_mb;
    logic             sw_eff_sub, sw_sr, sw_zero_res;

    pa_mag_swap #(
        .MAN_W (MAN_W)
    ) u_swap (
        .ge         (s1_ge),
        .eq         (s1_eq),
        .sa         (s1_sa),
        .sb         (s1_sb),
        .mant_a     (s1_ma),
        .mant_b     (s1_mb),
        .ma_c       (sw_ma),
        .mb_c       (sw_mb),
        .eff_sub_c  (sw_eff_sub),
        .sr_c       (sw_sr),
        .zero_res_c (sw_zero_res)
    );

    // S2: output register; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            comp      <= 1'b0;
            eo        <= '0;
            ma        <= '0;
            mb        <= '0;
            eff_sub   <= 1'b0;
            sr        <= 1'b0;
            zero_res  <= 1'b0;
            align_err <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sa        <= s1_sa;
                sb        <= s1_sb;
                comp      <= s1_ge;
                eo        <= s1_ea;
                ma        <= sw_ma;
                mb        <= sw_mb;
                eff_sub   <= sw_eff_sub;
                sr        <= sw_sr;
                zero_res  <= sw_zero_res;
                align_err <= s1_xerr;
            end
        end
    end

endmodule

// File: tb/tb_pa_mag_order_pipe.sv
// Scoreboard bench for pa_mag_order_pipe: directed cases on the default
// configuration, randomised traffic on a MAN_W=24 instance.
module tb_pa_mag_order_pipe;

    localparam int unsigned RES_W = 71;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Default-width instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [36:0] num_a, num_b;
    logic        sa, sb, comp, eff_sub, sr, zero_res, align_err;
    logic [7:0]  eo;
    logic [27:0] ma, mb;

    pa_mag_order_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_a     (num_a),
        .num_b     (num_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sa        (sa),
        .sb        (sb),
        .comp      (comp),
        .eo        (eo),
        .ma        (ma),
        .mb        (mb),
        .eff_sub   (eff_sub),
        .sr        (sr),
        .zero_res  (zero_res),
        .align_err (align_err)
    );

    // MAN_W = 24 instance for random traffic
    logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [32:0] r_num_a, r_num_b;
    logic        r_sa, r_sb, r_comp, r_eff_sub, r_sr, r_zero_res, r_align_err;
    logic [7:0]  r_eo;
    logic [23:0] r_ma, r_mb;
    logic        rand_en = 1'b0;

    pa_mag_order_pipe #(.EXP_W(8), .MAN_W(24)) u_dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_in_valid),
        .in_ready  (r_in_ready),
        .num_a     (r_num_a),
        .num_b     (r_num_b),
        .out_valid (r_out_valid),
        .out_ready (r_out_ready),
        .sa        (r_sa),
        .sb        (r_sb),
        .comp      (r_comp),
        .eo        (r_eo),
        .ma        (r_ma),
        .mb        (r_mb),
        .eff_sub   (r_eff_sub),
        .sr        (r_sr),
        .zero_res  (r_zero_res),
        .align_err (r_align_err)
    );

    logic [RES_W-1:0] exp_q[$];
    logic [RES_W-1:0] exp_q24[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] mk(input logic psa, input logic psb, input logic pc,
                                            input logic [7:0] peo, input logic [27:0] pma,
                                            input logic [27:0] pmb, input logic pe, input logic ps,
                                            input logic pz, input logic pae);
        return {psa, psb, pc, peo, pma, pmb, pe, ps, pz, pae};
    endfunction

    // Reference model of the ordering stage
    function automatic logic [RES_W-1:0] model(input logic xsa, input logic [7:0] xea,
                                               input logic [27:0] xma, input logic xsb,
                                               input logic [7:0] xeb, input logic [27:0] xmb);
        logic c, e, s, z;
        c = (xma >= xmb);
        e = xsa ^ xsb;
        z = e && (xma == xmb);
        if (!e)                s = xsa;
        else if (xma == xmb)   s = 1'b0;
        else if (xma > xmb)    s = xsa;
        else                   s = xsb;
        return mk(xsa, xsb, c, xea, c ? xma : xmb, c ? xmb : xma, e, s, z, xea != xeb);
    endfunction

    function automatic logic [RES_W-1:0] obs();
        return mk(sa, sb, comp, eo, ma, mb, eff_sub, sr, zero_res, align_err);
    endfunction

    function automatic logic [RES_W-1:0] obs24();
        return mk(r_sa, r_sb, r_comp, r_eo, {4'b0, r_ma}, {4'b0, r_mb},
                  r_eff_sub, r_sr, r_zero_res, r_align_err);
    endfunction

    // Output monitors: pop on transfer, compare against head while stalled
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0)
                check("spurious_out", 128'(out_valid), 128'(1'b0));
            else if (out_ready)
                check("result", 128'(obs()), 128'(exp_q.pop_front()));
            else
                check("hold", 128'(obs()), 128'(exp_q[0]));
        end
    end

    always @(negedge clk) begin
        if (rst_n && r_out_valid) begin
            if (exp_q24.size() == 0)
                check("spurious_out24", 128'(r_out_valid), 128'(1'b0));
            else if (r_out_ready)
                check("result24", 128'(obs24()), 128'(exp_q24.pop_front()));
            else
                check("hold24", 128'(obs24()), 128'(exp_q24[0]));
        end
    end

    always @(posedge clk) begin
        #1;
        r_out_ready = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Present a pair and wait for its accept edge
    task automatic send(input logic [36:0] a, input logic [36:0] b, input logic [RES_W-1:0] e);
        int waited = 0;
        in_valid = 1'b1;
        num_a    = a;
        num_b    = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 128'(in_ready), 128'(1'b1));
                break;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_m(input logic [36:0] a, input logic [36:0] b);
        send(a, b, model(a[36], a[35:28], a[27:0], b[36], b[35:28], b[27:0]));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic send24(input logic [32:0] a, input logic [32:0] b);
        int waited = 0;
        r_in_valid = 1'b1;
        r_num_a    = a;
        r_num_b    = b;
        forever begin
            @(negedge clk);
            if (r_in_ready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout24", 128'(r_in_ready), 128'(1'b1));
                break;
            end
        end
        exp_q24.push_back(model(a[32], a[31:24], {4'b0, a[23:0]},
                                b[32], b[31:24], {4'b0, b[23:0]}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        num_a      = '0;
        num_b      = '0;
        out_ready  = 1'b1;
        r_in_valid = 1'b0;
        r_num_a    = '0;
        r_num_b    = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_data", 128'(obs()), 128'(0));

        // Plain add, A larger; latency through both stages
        @(posedge clk); #1;
        send({1'b0, 8'h80, 28'h0A00000}, {1'b0, 8'h80, 28'h0500000},
             mk(1'b0, 1'b0, 1'b1, 8'h80, 28'h0A00000, 28'h0500000, 1'b0, 1'b0, 1'b0, 1'b0));
        idle();
        @(negedge clk);
        check("lat_s1", 128'(out_valid), 128'(1'b0));
        @(negedge clk);
        check("lat_s2", 128'(out_valid), 128'(1'b1));
        @(posedge clk); #1;

        // Back-to-back directed corner cases
        send({1'b0, 8'h81, 28'h0300000}, {1'b1, 8'h81, 28'h0700000},
             mk(1'b0, 1'b1, 1'b0, 8'h81, 28'h0700000, 28'h0300000, 1'b1, 1'b1, 1'b0, 1'b0));
        send({1'b1, 8'h7F, 28'h0800000}, {1'b0, 8'h7F, 28'h0800000},
             mk(1'b1, 1'b0, 1'b1, 8'h7F, 28'h0800000, 28'h0800000, 1'b1, 1'b0, 1'b1, 1'b0));
        send({1'b0, 8'h10, 28'h0001234}, {1'b0, 8'h11, 28'h0001000},
             mk(1'b0, 1'b0, 1'b1, 8'h10, 28'h0001234, 28'h0001000, 1'b0, 1'b0, 1'b0, 1'b1));
        send({1'b1, 8'h20, 28'h0}, {1'b1, 8'h20, 28'h0},
             mk(1'b1, 1'b1, 1'b1, 8'h20, 28'h0, 28'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        send({1'b1, 8'h20, 28'h0}, {1'b0, 8'h20, 28'h0},
             mk(1'b1, 1'b0, 1'b1, 8'h20, 28'h0, 28'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        send({1'b0, 8'hFF, 28'hFFFFFFF}, {1'b1, 8'hFF, 28'hFFFFFFE},
             mk(1'b0, 1'b1, 1'b1, 8'hFF, 28'hFFFFFFF, 28'hFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0));
        send({1'b1, 8'h01, 28'hFFFFFFE}, {1'b0, 8'h01, 28'hFFFFFFF},
             mk(1'b1, 1'b0, 1'b0, 8'h01, 28'hFFFFFFF, 28'hFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0));
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two pairs buffer, then input stalls
        out_ready = 1'b0;
        send_m({1'b0, 8'h40, 28'h0111111}, {1'b1, 8'h40, 28'h0222222});
        send_m({1'b1, 8'h41, 28'h0333333}, {1'b1, 8'h41, 28'h0333333});
        in_valid = 1'b1;
        num_a    = {1'b0, 8'h42, 28'h0444444};
        num_b    = {1'b1, 8'h43, 28'h0044444};
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'(1'b0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_m({1'b0, 8'h42, 28'h0444444}, {1'b1, 8'h43, 28'h0044444});
        send_m({1'b1, 8'h44, 28'h0555555}, {1'b0, 8'h44, 28'h0666666});
        send_m({1'b0, 8'h45, 28'h0777777}, {1'b0, 8'h45, 28'h0000001});
        idle();
        repeat (5) @(posedge clk);
        #1;
        check("bp_drain", 128'(exp_q.size()), 128'(0));

        // Reset with two pairs in flight
        out_ready = 1'b0;
        send_m({1'b0, 8'h50, 28'h0123456}, {1'b0, 8'h50, 28'h0654321});
        send_m({1'b1, 8'h51, 28'h0ABCDEF}, {1'b0, 8'h52, 28'h0ABCDEF});
        idle();
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("mid_rst_data", 128'(obs()), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle", 128'(out_valid), 128'(1'b0));
        end

        // Random traffic on the MAN_W = 24 instance
        @(posedge clk); #1;
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [23:0] m_a, m_b;
            logic [7:0]  e_a, e_b;
            int          mode;
            m_a  = 24'($urandom);
            m_b  = 24'($urandom);
            mode = int'($urandom_range(0, 7));
            if (mode == 0) m_b = m_a;
            if (mode == 1) begin m_a = '0; m_b = '0; end
            if (mode == 2) m_a = 24'hFFFFFF;
            if (mode == 3) m_b = 24'hFFFFFF;
            e_a = 8'($urandom);
            e_b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : e_a;
            if ($urandom_range(0, 3) == 0) begin
                r_in_valid = 1'b0;
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
            send24({1'($urandom), e_a, m_a}, {1'($urandom), e_b, m_b});
        end
        r_in_valid = 1'b0;
        rand_en    = 1'b0;
        for (int i = 0; i < 200 && exp_q24.size() != 0; i++) @(posedge clk);
        #1;
        check("rand_drain", 128'(exp_q24.size()), 128'(0));
        check("final_drain", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
